// File: rtl/a0_uart_tx_if.sv
// Status bus of the a0 UART reporter: monitored value in, serial line and status out.
interface a0_uart_tx_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic [WIDTH-1:0] a0;
  logic             tx;
  logic             busy;
  logic [7:0]       drop_cnt;

  modport master (output a0, input tx, input busy, input drop_cnt);
  modport slave  (input a0, output tx, output busy, output drop_cnt);
endinterface

// File: rtl/a0_uart_tx.sv
// Streams the monitored a0 value as uppercase hex plus CR/LF over an 8N1 UART
// whenever it differs from the last value sent.
module a0_uart_tx #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  a0_uart_tx_if.slave bus
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned NCHAR = NIB + 2;
  localparam int unsigned IDX_W = $clog2(NCHAR);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    NEXT
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a0_q, a0_d;
  logic [WIDTH-1:0]   last_sent_q, last_sent_d;
  logic [WIDTH-1:0]   frame_val_q, frame_val_d;
  logic [IDX_W-1:0]   char_idx_q, char_idx_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  logic               req;
  logic               bit_wrap;
  logic               stop_last;
  logic [IDX_W-1:0]   nib_pos;
  logic [IDX_W+1:0]   nib_sh;
  logic [3:0]         nib;
  logic [7:0]         char_byte;

  assign req       = (a0_q != last_sent_q);
  assign bit_wrap  = (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign stop_last = (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 2));

  // Character being shifted out: hex nibbles MSB first, then CR, then LF.
  always_comb begin
    nib_pos   = IDX_W'(NIB - 1) - char_idx_q;
    nib_sh    = {nib_pos, 2'b00};
    nib       = 4'(frame_val_q >> nib_sh);
    char_byte = 8'h0A;
    if (char_idx_q < IDX_W'(NIB)) begin
      char_byte = (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
    end else if (char_idx_q == IDX_W'(NIB)) begin
      char_byte = 8'h0D;
    end
  end

  // Input sampling and superseded-value counting; a return to the value in
  // flight is a cancellation rather than a drop.
  always_comb begin
    a0_d       = bus.a0;
    drop_cnt_d = drop_cnt_q;
    if ((state_q != IDLE) && (bus.a0 != a0_q) && (a0_q != last_sent_q) &&
        (bus.a0 != last_sent_q) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Frame sequencer; tx is the registered level of the current state, so the
  // line trails the state by one cycle. NEXT is the last cycle of the stop bit.
  always_comb begin
    state_d     = state_q;
    last_sent_d = last_sent_q;
    frame_val_d = frame_val_q;
    char_idx_d  = char_idx_q;
    bit_idx_d   = bit_idx_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = 1'b1;
    case (state_q)
      IDLE: begin
        if (req) begin
          frame_val_d = a0_q;
          last_sent_d = a0_q;
          char_idx_d  = '0;
          bit_idx_d   = '0;
          bit_cnt_d   = '0;
          state_d     = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_wrap) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        tx_d = char_byte[bit_idx_q];
        if (bit_wrap) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        tx_d      = 1'b1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (stop_last) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        tx_d      = 1'b1;
        bit_cnt_d = '0;
        if (char_idx_q == IDX_W'(NCHAR - 1)) begin
          state_d = IDLE;
        end else begin
          char_idx_d = char_idx_q + IDX_W'(1);
          state_d    = START;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      a0_q        <= '0;
      last_sent_q <= '0;
      frame_val_q <= '0;
      char_idx_q  <= '0;
      bit_idx_q   <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      a0_q        <= a0_d;
      last_sent_q <= last_sent_d;
      frame_val_q <= frame_val_d;
      char_idx_q  <= char_idx_d;
      bit_idx_q   <= bit_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule
